// File: rtl/dm_banked_ctrl.sv
// Word-organised data memory behind a request/response handshake with
// programmable wait states and alignment/range/size error reporting.
module dm_banked_ctrl #(
  parameter int          DEPTH    = 100,
  parameter int          ADDR_W   = 32,
  parameter int          LATENCY  = 0,
  parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [3:0]         cnt_r, cnt_nx_s;
  logic               we_r;
  logic [2:0]         size_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic               req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0]        resp_rdata_r;
  logic [31:0]        mem_r [DEPTH];

  logic               accept_s, resolve_s, err_s;
  logic               res_we_s;
  logic [2:0]         res_size_s;
  logic [ADDR_W-1:0]  res_addr_s;
  logic [31:0]        res_wdata_s;
  logic [IDX_W-1:0]   idx_s;
  logic [31:0]        rd_word_s, wr_word_s, sdata_s;
  logic [3:0]         be_s;

  // Legal sizes: B/H/W for both directions, BU/HU for loads only.
  function automatic logic access_err(input logic we, input logic [2:0] size,
                                      input logic [ADDR_W-1:0] addr);
    logic e;
    case (size)
      3'b000:  e = 1'b0;
      3'b001:  e = addr[0];
      3'b010:  e = (addr[1:0] != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | addr[0];
      default: e = 1'b1;
    endcase
    return e | (addr[ADDR_W-1:2] >= DEPTH_L);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] size,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, sh[7:0]};
      3'b101:  r = {16'h0000, sh[15:0]};
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] r;
    case (size)
      3'b000:  r = 4'b0001 << lane;
      3'b001:  r = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      3'b000:  r = {4{wdata[7:0]}};
      3'b001:  r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept_s = req_valid && req_ready_r && (state_r == ST_IDLE);

  // Next-state and wait-counter logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY > 0) begin
            state_nx_s = ST_WAIT;
            cnt_nx_s   = WAIT_INIT;
          end else begin
            state_nx_s = ST_RESP;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = ST_RESP;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // With zero wait states the access resolves on the accepting edge, so use live inputs.
  always_comb begin
    if (state_r == ST_IDLE) begin
      res_we_s    = req_we;
      res_size_s  = req_size;
      res_addr_s  = req_addr;
      res_wdata_s = req_wdata;
    end else begin
      res_we_s    = we_r;
      res_size_s  = size_r;
      res_addr_s  = addr_r;
      res_wdata_s = wdata_r;
    end
  end

  // Access decode and store byte merge
  always_comb begin
    resolve_s = (state_nx_s == ST_RESP);
    err_s     = access_err(res_we_s, res_size_s, res_addr_s);
    idx_s     = res_addr_s[IDX_W+1:2];
    rd_word_s = mem_r[idx_s];
    be_s      = store_be(res_size_s, res_addr_s[1:0]);
    sdata_s   = store_data(res_size_s, res_wdata_s);
    wr_word_s = rd_word_s;
    for (int b = 0; b < 4; b++) begin
      if (be_s[b]) begin
        wr_word_s[b*8 +: 8] = sdata_s[b*8 +: 8];
      end else begin
        wr_word_s[b*8 +: 8] = rd_word_s[b*8 +: 8];
      end
    end
  end

  // Control state, request capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      size_r       <= 3'b000;
      addr_r       <= '0;
      wdata_r      <= 32'h00000000;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h00000000;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      req_ready_r  <= (state_nx_s == ST_IDLE);
      resp_valid_r <= (state_nx_s == ST_RESP);
      if (accept_s) begin
        we_r    <= req_we;
        size_r  <= req_size;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (resolve_s) begin
        resp_err_r <= err_s;
        if (err_s) begin
          resp_rdata_r <= ERR_CODE;
        end else if (res_we_s) begin
          resp_rdata_r <= 32'h00000000;
        end else begin
          resp_rdata_r <= load_ext(rd_word_s, res_size_s, res_addr_s[1:0]);
        end
      end
    end
  end

  // Storage array; deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (resolve_s && res_we_s && !err_s) begin
      mem_r[idx_s] <= wr_word_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Randomised bench for dm_banked_ctrl: two instances (0 and 3 wait states)
// checked against a byte-array reference model plus directed corner cases.
module tb_dm_banked_ctrl;

  localparam int DEPTH = 100;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];

  int checks = 0;
  int failures = 0;
  bit [7:0] bmem [2][4*DEPTH];

  dm_banked_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(0), .ERR_CODE(32'hDEAD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dm_banked_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(3), .ERR_CODE(32'hDEAD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: byte-addressed memory, access rules from size/alignment/range arithmetic.
  task automatic model_access(input int d, input bit we, input bit [2:0] size,
                              input bit [31:0] addr, input bit [31:0] wdata,
                              output bit exp_err, output bit [31:0] exp_rd);
    int n;
    bit [31:0] v;
    bit [31:0] mask;
    case (size)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    exp_err = (n == 0) || (we && size >= 3'd4);
    if (n != 0 && (addr % n) != 0) exp_err = 1'b1;
    if ((addr / 4) >= DEPTH) exp_err = 1'b1;
    if (exp_err) begin
      exp_rd = 32'h0000DEAD;
    end else if (we) begin
      for (int i = 0; i < n; i++) bmem[d][int'(addr) + i] = wdata[8*i +: 8];
      exp_rd = 32'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(bmem[d][int'(addr) + i]) << (8*i));
      if (n < 4 && size < 3'd4 && v[8*n-1]) begin
        mask = (32'h1 << (8*n)) - 32'h1;
        v = v | ~mask;
      end
      exp_rd = v;
    end
  endtask

  task automatic do_txn(input int d, input bit we, input bit [2:0] size, input bit [31:0] addr,
                        input bit [31:0] wdata, output logic [31:0] got_rd);
    bit exp_err;
    bit [31:0] exp_rd;
    bit seen;
    int k;
    model_access(d, we, size, addr, wdata, exp_err, exp_rd);
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid[d] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_ready[d]) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("ready_before_accept", 32'(seen), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid[d]) seen = 1'b1;
      else check_eq("ready_low_wait", 32'(req_ready[d]), 32'd0);
    end
    check_eq("resp_latency", 32'(k), 32'(1 + lat_of(d)));
    check_eq("ready_low_resp", 32'(req_ready[d]), 32'd0);
    got_rd = resp_rdata[d];
    check_eq("rdata", resp_rdata[d], exp_rd);
    check_eq("err", 32'(resp_err[d]), 32'(exp_err));
    @(negedge clk);
    check_eq("valid_pulse", 32'(resp_valid[d]), 32'd0);
    check_eq("rdata_hold", resp_rdata[d], exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] prev;
    bit e;
    bit [31:0] x;
    bit [2:0] sz;
    bit [31:0] ad;
    int d;
    rst_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_we = 1'b0; req_size = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ready", 32'(req_ready[i]), 32'd1);
      check_eq("rst_valid", 32'(resp_valid[i]), 32'd0);
      check_eq("rst_rdata", resp_rdata[i], 32'h0);
      check_eq("rst_err", 32'(resp_err[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Give every word a known value in both instances and the model.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++) do_txn(i, 1'b1, 3'd2, 32'(4*w), $urandom, rd);

    // Basic word store/load and sub-word lanes.
    do_txn(0, 1'b1, 3'd2, 32'h08, 32'h12345678, rd);
    check_eq("t1_sw_rdata", rd, 32'h0);
    do_txn(0, 1'b0, 3'd2, 32'h08, 32'h0, rd);
    check_eq("t1_lw", rd, 32'h12345678);
    do_txn(0, 1'b1, 3'd0, 32'h09, 32'h00000080, rd);
    do_txn(0, 1'b0, 3'd0, 32'h09, 32'h0, rd);
    check_eq("t2_lb", rd, 32'hFFFFFF80);
    do_txn(0, 1'b0, 3'd4, 32'h09, 32'h0, rd);
    check_eq("t2_lbu", rd, 32'h00000080);
    do_txn(0, 1'b0, 3'd2, 32'h08, 32'h0, rd);
    check_eq("t2_lw", rd, 32'h12348078);

    // Misalignment and range errors.
    do_txn(0, 1'b0, 3'd1, 32'h03, 32'h0, rd);
    check_eq("t3_lh_mis", rd, 32'h0000DEAD);
    do_txn(0, 1'b1, 3'd2, 32'h0A, 32'hFFFFFFFF, rd);
    check_eq("t3_sw_mis", rd, 32'h0000DEAD);
    do_txn(0, 1'b0, 3'd2, 32'h08, 32'h0, rd);
    check_eq("t3_unchanged", rd, 32'h12348078);
    do_txn(0, 1'b0, 3'd2, 32'h0, 32'h0, prev);
    do_txn(0, 1'b0, 3'd2, 32'(4*DEPTH), 32'h0, rd);
    check_eq("t4_lw_range", rd, 32'h0000DEAD);
    do_txn(0, 1'b1, 3'd2, 32'(4*DEPTH), 32'hA5A5A5A5, rd);
    do_txn(0, 1'b0, 3'd2, 32'h0, 32'h0, rd);
    check_eq("t4_no_wrap", rd, prev);

    // Three wait states with req_valid held across two requests.
    model_access(1, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, e, x);
    @(negedge clk);
    req_we = 1'b1; req_size = 3'd2; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    req_valid[1] = 1'b1;
    check_eq("t5_ready0", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq("t5_ready", 32'(req_ready[1]), 32'(k == 5));
      check_eq("t5_valid", 32'(resp_valid[1]), 32'(k == 4));
      if (k == 4) check_eq("t5_st_err", 32'(resp_err[1]), 32'd0);
    end
    req_we = 1'b0;
    model_access(1, 1'b0, 3'd2, 32'h20, 32'h0, e, x);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("t5_valid2", 32'(resp_valid[1]), 32'(k == 4));
    end
    check_eq("t5_lw", resp_rdata[1], 32'h0BADF00D);

    // Reset during WAIT drops the store.
    do_txn(1, 1'b0, 3'd2, 32'h10, 32'h0, prev);
    @(negedge clk);
    req_we = 1'b1; req_size = 3'd2; req_addr = 32'h10; req_wdata = ~prev;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(req_ready[1]), 32'd1);
    check_eq("t6_rst_valid", 32'(resp_valid[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t6_no_pulse", 32'(resp_valid[1]), 32'd0);
    end
    do_txn(1, 1'b0, 3'd2, 32'h10, 32'h0, rd);
    check_eq("t6_prior", rd, prev);

    // Random mix over both instances.
    for (int t = 0; t < 400; t++) begin
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
        0:       sz = 3'd3;
        1:       sz = 3'd6;
        2:       sz = 3'd7;
        3, 4:    sz = 3'd0;
        5, 6:    sz = 3'd1;
        7, 8:    sz = 3'd2;
        9:       sz = 3'd4;
        default: sz = 3'd5;
      endcase
      if ($urandom_range(0, 9) == 0) ad = $urandom;
      else ad = $urandom_range(0, 4*DEPTH + 7);
      do_txn(d, 1'($urandom_range(0, 1)), sz, ad, $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
